video_timing_sync: RTL and testbench

- Parametrised successor to the fixed 720p video signal generator.
- Produces raster counters, sync, active-draw, new-frame and frame-count outputs for any timing set by parameters.
- Also produces pixel-replicated (scaled) coordinates for low-resolution renderers.
- Owns the N-renderer frame handshake: kicks all renderers together at a frame boundary, tracks a double-buffer select, and counts dropped frames.

---
 rtl/video_timing_sync_if.sv | 25 ++
 rtl/video_timing_sync.sv | 139 +++++++++++++
 tb/tb_video_timing_sync.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_sync_if.sv
// Renderer frame handshake bundle between the timing generator (master) and
// the renderer group (slave).
interface video_timing_sync_if #(
   parameter int NUM_RENDERERS = 2,
   parameter int DROP_W        = 8
);
   logic [NUM_RENDERERS-1:0] done_in;
   logic                     start_out;
   logic                     buf_sel_out;
   logic [DROP_W-1:0]        drop_count_out;

   modport master (
      input  done_in,
      output start_out,
      output buf_sel_out,
      output drop_count_out
   );

   modport slave (
      output done_in,
      input  start_out,
      input  buf_sel_out,
      input  drop_count_out
   );
endinterface

// File: rtl/video_timing_sync.sv
// Parametrised raster timing generator with scaled coordinates and N-renderer frame kick.
// Optional colour-bar test pattern output enabled by VIDEO_TIMING_SYNC_PATTERN_EN.
module video_timing_sync #(
   parameter int ACTIVE_H      = 1280,
   parameter int FP_H          = 110,
   parameter int SYNC_H        = 40,
   parameter int BP_H          = 220,
   parameter int ACTIVE_V      = 720,
   parameter int FP_V          = 5,
   parameter int SYNC_V        = 5,
   parameter int BP_V          = 20,
   parameter bit HS_POL        = 1'b1,
   parameter bit VS_POL        = 1'b1,
   parameter int FRAME_WRAP    = 60,
   parameter int SCALE_SHIFT   = 2,
   parameter int NUM_RENDERERS = 2,
   parameter int H_W           = 11,
   parameter int V_W           = 10,
   parameter int DROP_W        = 8
) (
   input  logic                clk_pixel_in,
   input  logic                rst_in,
   output logic [H_W-1:0]      hcount_out,
   output logic [V_W-1:0]      vcount_out,
   output logic [H_W-1:0]      hcount_scaled_out,
   output logic [V_W-1:0]      vcount_scaled_out,
   output logic                hs_out,
   output logic                vs_out,
   output logic                ad_out,
   output logic                nf_out,
   output logic [5:0]          fc_out,
`ifdef VIDEO_TIMING_SYNC_PATTERN_EN
   output logic [23:0]         pattern_out,
`endif
   video_timing_sync_if.master rnd
);
   localparam int TOTAL_H = ACTIVE_H + FP_H + SYNC_H + BP_H;
   localparam int TOTAL_V = ACTIVE_V + FP_V + SYNC_V + BP_V;

   localparam logic [H_W-1:0]    H_ACT   = H_W'(ACTIVE_H);
   localparam logic [H_W-1:0]    HS_BEG  = H_W'(ACTIVE_H + FP_H);
   localparam logic [H_W-1:0]    HS_END  = H_W'(ACTIVE_H + FP_H + SYNC_H);
   localparam logic [H_W-1:0]    H_LAST  = H_W'(TOTAL_H - 1);
   localparam logic [V_W-1:0]    V_ACT   = V_W'(ACTIVE_V);
   localparam logic [V_W-1:0]    VS_BEG  = V_W'(ACTIVE_V + FP_V);
   localparam logic [V_W-1:0]    VS_END  = V_W'(ACTIVE_V + FP_V + SYNC_V);
   localparam logic [V_W-1:0]    V_LAST  = V_W'(TOTAL_V - 1);
   localparam logic [5:0]        FC_LAST = 6'(FRAME_WRAP - 1);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   // Internal raster position; the registered outputs trail it by one edge.
   logic [H_W-1:0]           h_q;
   logic [V_W-1:0]           v_q;
   logic [NUM_RENDERERS-1:0] done_q;

   logic h_last, v_last, ad_d, hs_d, vs_d, nf_d, all_done;

   always_comb begin
      h_last   = (h_q == H_LAST);
      v_last   = (v_q == V_LAST);
      ad_d     = (h_q < H_ACT) && (v_q < V_ACT);
      hs_d     = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d     = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
      nf_d     = (h_q == H_ACT) && (v_q == V_ACT);
      all_done = ((done_q | rnd.done_in) == '1);
   end

`ifdef VIDEO_TIMING_SYNC_PATTERN_EN
   logic [2:0]  bar_idx;
   logic [23:0] colour_d;

   always_comb begin
      bar_idx  = 3'((32'(h_q) * 32'd8) / 32'(ACTIVE_H));
      colour_d = 24'h000000;
      case (bar_idx)
         3'd0:    colour_d = 24'hFFFFFF;
         3'd1:    colour_d = 24'hFFFF00;
         3'd2:    colour_d = 24'h00FFFF;
         3'd3:    colour_d = 24'h00FF00;
         3'd4:    colour_d = 24'hFF00FF;
         3'd5:    colour_d = 24'hFF0000;
         3'd6:    colour_d = 24'h0000FF;
         default: colour_d = 24'h000000;
      endcase
   end

   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) pattern_out <= '0;
      else        pattern_out <= ad_d ? colour_d : 24'h000000;
   end
`endif

   // Handshake: start_out is a one-cycle valid with no ready; a renderer
   // acknowledges the frame by raising done_in (level or pulse) at any point
   // before the next boundary, and a boundary without all acks is a drop.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         h_q                <= '0;
         v_q                <= '0;
         done_q             <= '1;
         hcount_out         <= '0;
         vcount_out         <= '0;
         hcount_scaled_out  <= '0;
         vcount_scaled_out  <= '0;
         hs_out             <= 1'b0;
         vs_out             <= 1'b0;
         ad_out             <= 1'b0;
         nf_out             <= 1'b0;
         fc_out             <= '0;
         rnd.start_out      <= 1'b0;
         rnd.buf_sel_out    <= 1'b0;
         rnd.drop_count_out <= '0;
      end else begin
         h_q <= h_last ? '0 : h_q + H_W'(1);
         if (h_last) v_q <= v_last ? '0 : v_q + V_W'(1);

         hcount_out        <= h_q;
         vcount_out        <= v_q;
         hcount_scaled_out <= h_q >> SCALE_SHIFT;
         vcount_scaled_out <= v_q >> SCALE_SHIFT;
         hs_out            <= hs_d;
         vs_out            <= vs_d;
         ad_out            <= ad_d;
         nf_out            <= nf_d;
         if (nf_d) fc_out  <= (fc_out == FC_LAST) ? 6'd0 : fc_out + 6'd1;

         rnd.start_out <= nf_d && all_done;
         if (nf_d && all_done) begin
            // Clearing takes priority over a done_in seen in the same cycle.
            rnd.buf_sel_out <= ~rnd.buf_sel_out;
            done_q          <= '0;
         end else begin
            done_q <= done_q | rnd.done_in;
            if (nf_d && (rnd.drop_count_out != DROP_MAX))
               rnd.drop_count_out <= rnd.drop_count_out + DROP_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_video_timing_sync.sv
// Bench for video_timing_sync: a small-raster instance checked every cycle against a
// cycle-count arithmetic model, plus a 640-wide negative-sync instance for line timing.
module tb_video_timing_sync;
   // Instance A: tiny raster so many frames fit in a short run.
   localparam int AH = 16, AFH = 3, ASH = 4, ABH = 5;
   localparam int AV = 8,  AFV = 2, ASV = 3, ABV = 2;
   localparam int ATH = AH + AFH + ASH + ABH;   // 28
   localparam int ATV = AV + AFV + ASV + ABV;   // 15
   localparam int AFW = 5;
   localparam int AFRAME = ATH * ATV;           // 420
   // Instance B: 640-wide line with active-low hsync.
   localparam int BTH = 800;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   video_timing_sync_if #(.NUM_RENDERERS(2), .DROP_W(2)) a_if ();
   video_timing_sync_if #(.NUM_RENDERERS(1), .DROP_W(8)) b_if ();

   logic [4:0] a_h, a_hsc;
   logic [3:0] a_v, a_vsc;
   logic       a_hs, a_vs, a_ad, a_nf;
   logic [5:0] a_fc;
   logic [9:0] b_h, b_hsc;
   logic [2:0] b_v, b_vsc;
   logic       b_hs, b_vs, b_ad, b_nf;
   logic [5:0] b_fc;

   video_timing_sync #(
      .ACTIVE_H(AH), .FP_H(AFH), .SYNC_H(ASH), .BP_H(ABH),
      .ACTIVE_V(AV), .FP_V(AFV), .SYNC_V(ASV), .BP_V(ABV),
      .HS_POL(1'b1), .VS_POL(1'b0), .FRAME_WRAP(AFW), .SCALE_SHIFT(2),
      .NUM_RENDERERS(2), .H_W(5), .V_W(4), .DROP_W(2)
   ) dut_a (
      .clk_pixel_in(clk), .rst_in(rst),
      .hcount_out(a_h), .vcount_out(a_v),
      .hcount_scaled_out(a_hsc), .vcount_scaled_out(a_vsc),
      .hs_out(a_hs), .vs_out(a_vs), .ad_out(a_ad), .nf_out(a_nf), .fc_out(a_fc),
      .rnd(a_if.master)
   );

   video_timing_sync #(
      .ACTIVE_H(640), .FP_H(16), .SYNC_H(96), .BP_H(48),
      .ACTIVE_V(4), .FP_V(1), .SYNC_V(1), .BP_V(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .FRAME_WRAP(60), .SCALE_SHIFT(1),
      .NUM_RENDERERS(1), .H_W(10), .V_W(3), .DROP_W(8)
   ) dut_b (
      .clk_pixel_in(clk), .rst_in(rst),
      .hcount_out(b_h), .vcount_out(b_v),
      .hcount_scaled_out(b_hsc), .vcount_scaled_out(b_vsc),
      .hs_out(b_hs), .vs_out(b_vs), .ad_out(b_ad), .nf_out(b_nf), .fc_out(b_fc),
      .rnd(b_if.master)
   );

   logic [31:0] a_obs;
   assign a_obs = {a_h, a_v, a_hsc, a_vsc, a_hs, a_vs, a_ad, a_nf, a_fc,
                   a_if.start_out, a_if.buf_sel_out, a_if.drop_count_out};

   // Reference model: position is a pure function of cycles since reset release.
   int       m_t = 0;
   bit       m_rst = 1'b1;
   bit [1:0] m_flags = 2'b11;
   bit       m_start = 1'b0;
   bit       m_buf = 1'b0;
   int       m_drop = 0;

   function automatic int e_h();
      return m_rst ? 0 : m_t % ATH;
   endfunction

   function automatic int e_v();
      return m_rst ? 0 : (m_t / ATH) % ATV;
   endfunction

   function automatic bit e_ad();
      return !m_rst && (e_h() < AH) && (e_v() < AV);
   endfunction

   function automatic bit e_hs();
      if (m_rst) return 1'b0;
      return (e_h() >= AH + AFH) && (e_h() < AH + AFH + ASH);
   endfunction

   function automatic bit e_vs();
      if (m_rst) return 1'b0;
      return !((e_v() >= AV + AFV) && (e_v() < AV + AFV + ASV));
   endfunction

   function automatic bit e_nf();
      return !m_rst && (e_h() == AH) && (e_v() == AV);
   endfunction

   function automatic int e_fc();
      int base;
      base = AH + AV * ATH;
      if (m_rst || m_t < base) return 0;
      return ((m_t - base) / AFRAME + 1) % AFW;
   endfunction

   function automatic logic [31:0] exp_vec();
      int h, v;
      h = e_h();
      v = e_v();
      return {5'(h), 4'(v), 5'(h >> 2), 4'(v >> 2), e_hs(), e_vs(), e_ad(), e_nf(),
              6'(e_fc()), m_start, m_buf, 2'(m_drop)};
   endfunction

   function automatic void model_step();
      if (rst) begin
         m_rst = 1'b1; m_t = 0; m_flags = 2'b11; m_buf = 1'b0; m_drop = 0; m_start = 1'b0;
      end else begin
         if (m_rst) m_t = 0;
         else       m_t++;
         m_rst   = 1'b0;
         m_start = 1'b0;
         if (e_nf() && ((m_flags | a_if.done_in) == 2'b11)) begin
            m_start = 1'b1;
            m_buf   = ~m_buf;
            m_flags = 2'b00;
         end else begin
            m_flags = m_flags | a_if.done_in;
            if (e_nf() && m_drop < 3) m_drop++;
         end
      end
   endfunction

   // ---------------- clock / drive ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic run_to_nf(input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!e_nf() && n < budget);
      if (!e_nf()) begin
         n_vec++; n_err++;
         $display("FAIL nf_timeout: no frame boundary within %0d cycles (t=%0d)", budget, m_t);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      a_if.done_in = 2'b00;
      do_reset(3);
      n_vec++;
      if (a_obs !== 32'h0) begin
         n_err++; $display("FAIL reset_outputs: got %h required 00000000", a_obs);
      end
      tick();
      n_vec++;
      if (a_h !== 5'd0 || a_v !== 4'd0) begin
         n_err++; $display("FAIL first_pos: got (%0d,%0d) required (0,0)", a_h, a_v);
      end
      n_vec++;
      if (a_ad !== 1'b1 || a_hs !== 1'b0 || a_vs !== 1'b1 || a_nf !== 1'b0) begin
         n_err++; $display("FAIL first_flags: ad/hs/vs/nf got %b%b%b%b required 1010",
                           a_ad, a_hs, a_vs, a_nf);
      end
      n_vec++;
      if (b_hs !== 1'b1) begin
         n_err++; $display("FAIL first_hs_neg: got %b required 1", b_hs);
      end
   endtask

   task automatic test_raster();
      do_reset(2);
      for (int i = 0; i <= 6 * AFRAME + 49; i++) begin
         a_if.done_in = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         tick();
         n_vec++;
         if (a_obs !== exp_vec()) begin
            n_err++; $display("FAIL raster t=%0d: got %h required %h", m_t, a_obs, exp_vec());
         end
      end
      a_if.done_in = 2'b00;
      n_vec++;
      if (a_fc !== 6'd1) begin
         n_err++; $display("FAIL fc_wrap: after 6 frames got %0d required 1", a_fc);
      end
   endtask

   task automatic test_handshake();
      a_if.done_in = 2'b00;
      do_reset(2);
      run_to_nf(2 * AFRAME);
      n_vec++;
      if (a_h !== 5'd16 || a_v !== 4'd8 || a_nf !== 1'b1 || a_fc !== 6'd1) begin
         n_err++; $display("FAIL first_nf: got h=%0d v=%0d nf=%b fc=%0d required 16 8 1 1",
                           a_h, a_v, a_nf, a_fc);
      end
      n_vec++;
      if (a_if.start_out !== 1'b1 || a_if.buf_sel_out !== 1'b1 || a_if.drop_count_out !== 2'd0) begin
         n_err++; $display("FAIL kick_after_reset: start/buf/drop got %b %b %0d required 1 1 0",
                           a_if.start_out, a_if.buf_sel_out, a_if.drop_count_out);
      end
      tick();
      n_vec++;
      if (a_if.start_out !== 1'b0) begin
         n_err++; $display("FAIL start_width: got %b required 0", a_if.start_out);
      end
      run_to_nf(2 * AFRAME);
      n_vec++;
      if (a_if.start_out !== 1'b0 || a_if.drop_count_out !== 2'd1 || a_if.buf_sel_out !== 1'b1) begin
         n_err++; $display("FAIL first_drop: start/buf/drop got %b %b %0d required 0 1 1",
                           a_if.start_out, a_if.buf_sel_out, a_if.drop_count_out);
      end
      repeat (5) tick();
      a_if.done_in = 2'b01; tick(); a_if.done_in = 2'b00;
      repeat (40) tick();
      a_if.done_in = 2'b10; tick(); a_if.done_in = 2'b00;
      run_to_nf(2 * AFRAME);
      n_vec++;
      if (a_if.start_out !== 1'b1 || a_if.buf_sel_out !== 1'b0 || a_if.drop_count_out !== 2'd1) begin
         n_err++; $display("FAIL pulsed_done: start/buf/drop got %b %b %0d required 1 0 1",
                           a_if.start_out, a_if.buf_sel_out, a_if.drop_count_out);
      end
      a_if.done_in = 2'b11;
      run_to_nf(2 * AFRAME);
      a_if.done_in = 2'b00;
      n_vec++;
      if (a_if.start_out !== 1'b1 || a_if.buf_sel_out !== 1'b1) begin
         n_err++; $display("FAIL held_done: start/buf got %b %b required 1 1",
                           a_if.start_out, a_if.buf_sel_out);
      end
      run_to_nf(2 * AFRAME);
      n_vec++;
      if (a_if.start_out !== 1'b0 || a_if.drop_count_out !== 2'd2) begin
         n_err++; $display("FAIL clear_wins: start/drop got %b %0d required 0 2",
                           a_if.start_out, a_if.drop_count_out);
      end
   endtask

   task automatic test_drop_saturate();
      int exp_drop[6] = '{0, 1, 2, 3, 3, 3};
      bit exp_start[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      a_if.done_in = 2'b00;
      do_reset(2);
      for (int k = 0; k < 6; k++) begin
         run_to_nf(2 * AFRAME);
         n_vec++;
         if (a_if.drop_count_out !== 2'(exp_drop[k]) || a_if.start_out !== exp_start[k]) begin
            n_err++; $display("FAIL drop_sat frame %0d: drop/start got %0d %b required %0d %b",
                              k, a_if.drop_count_out, a_if.start_out, exp_drop[k], exp_start[k]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      a_if.done_in = 2'b00;
      do_reset(2);
      run_to_nf(2 * AFRAME);
      run_to_nf(2 * AFRAME);
      a_if.done_in = 2'b11;
      repeat (100) tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (a_obs !== 32'h0 || b_hs !== 1'b0 || b_h !== 10'd0 || b_if.buf_sel_out !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: A=%h B hs=%b h=%0d buf=%b required all zero",
                              a_obs, b_hs, b_h, b_if.buf_sel_out);
         end
      end
      rst = 1'b0;
      run_to_nf(2 * AFRAME);
      n_vec++;
      if (a_if.start_out !== 1'b1 || a_if.drop_count_out !== 2'd0 || a_if.buf_sel_out !== 1'b1) begin
         n_err++; $display("FAIL after_mid_reset: start/buf/drop got %b %b %0d required 1 1 0",
                           a_if.start_out, a_if.buf_sel_out, a_if.drop_count_out);
      end
      a_if.done_in = 2'b00;
   endtask

   task automatic test_alt_timing();
      int bh, seen;
      seen = 0;
      do_reset(2);
      for (int i = 0; i < BTH + 200; i++) begin
         tick();
         bh = m_t % BTH;
         n_vec++;
         if (b_h !== 10'(bh) || b_hs !== !(bh >= 656 && bh < 752) || b_hsc !== 10'(bh >> 1)) begin
            n_err++; $display("FAIL alt_line t=%0d: h/hs/hsc got %0d %b %0d required %0d %b %0d",
                              m_t, b_h, b_hs, b_hsc, bh, !(bh >= 656 && bh < 752), bh >> 1);
         end
         if (bh == 640) begin
            seen = 1;
            n_vec++;
            if (b_hsc !== 10'd320) begin
               n_err++; $display("FAIL alt_scaled_640: got %0d required 320", b_hsc);
            end
         end
      end
      n_vec++;
      if (seen != 1) begin
         n_err++; $display("FAIL alt_scaled_640: position 640 never reached");
      end
   endtask

   initial begin
      b_if.done_in = 1'b1;
      a_if.done_in = 2'b00;
      test_reset();
      test_raster();
      test_handshake();
      test_drop_saturate();
      test_reset_mid_frame();
      test_alt_timing();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end
endmodule
